reg_file_param: RTL and testbench

//  Parametrised register file for the single-cycle CPU datapath:
//  1 write port, 2 asynchronous read ports.

---
 rtl/reg_file_param.sv | 131 +++++++++++++
 tb/tb_reg_file_param.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/reg_file_param.sv
// rtl/reg_file_param.sv - parametrised register file with valid bits, clear sweep and optional write bypass
// Optional feature: define REG_FILE_BYPASS_EN for same-cycle write->read forwarding.
module reg_file_param #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter bit ZERO_REG0  = 1'b0
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [DATA_WIDTH-1:0] IN,
  input  logic [ADDR_WIDTH-1:0] INADDRESS,
  input  logic                  WRITE,
  input  logic [ADDR_WIDTH-1:0] OUT1ADDRESS,
  input  logic [ADDR_WIDTH-1:0] OUT2ADDRESS,
  output logic [DATA_WIDTH-1:0] OUT1,
  output logic [DATA_WIDTH-1:0] OUT2,
  output logic                  VALID1,
  output logic                  VALID2,
  input  logic                  CLEAR,
  output logic                  BUSY
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR = {ADDR_WIDTH{1'b1}};

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0]   regs_q [DEPTH];
  logic [DEPTH-1:0]        valid_q;
  logic                    wr_accept;
  logic                    addr0_blocked;

  assign BUSY          = (state_q == SWEEP);
  assign addr0_blocked = ZERO_REG0 && (INADDRESS == '0);
  assign wr_accept     = WRITE && !RESET && !BUSY && !CLEAR && !addr0_blocked;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (CLEAR) begin
          state_d = SWEEP;
          ptr_d   = '0;
        end
      end
      SWEEP: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == LAST_PTR) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Sweep clears one entry per edge; accepted writes only happen in IDLE.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      valid_q <= '0;
    end else if (state_q == SWEEP) begin
      regs_q[ptr_q]  <= '0;
      valid_q[ptr_q] <= 1'b0;
    end else if (wr_accept) begin
      regs_q[INADDRESS]  <= IN;
      valid_q[INADDRESS] <= 1'b1;
    end
  end

  logic [DATA_WIDTH-1:0] rd1_data, rd2_data;
  logic                  rd1_valid, rd2_valid;

  always_comb begin
    rd1_data  = regs_q[OUT1ADDRESS];
    rd1_valid = valid_q[OUT1ADDRESS];
    rd2_data  = regs_q[OUT2ADDRESS];
    rd2_valid = valid_q[OUT2ADDRESS];
    if (ZERO_REG0 && (OUT1ADDRESS == '0)) begin
      rd1_data  = '0;
      rd1_valid = 1'b1;
    end
    if (ZERO_REG0 && (OUT2ADDRESS == '0)) begin
      rd2_data  = '0;
      rd2_valid = 1'b1;
    end
  end

`ifdef REG_FILE_BYPASS_EN
  always_comb begin
    OUT1   = rd1_data;
    VALID1 = rd1_valid;
    OUT2   = rd2_data;
    VALID2 = rd2_valid;
    if (wr_accept && (OUT1ADDRESS == INADDRESS)) begin
      OUT1   = IN;
      VALID1 = 1'b1;
    end
    if (wr_accept && (OUT2ADDRESS == INADDRESS)) begin
      OUT2   = IN;
      VALID2 = 1'b1;
    end
  end
`else
  assign OUT1   = rd1_data;
  assign VALID1 = rd1_valid;
  assign OUT2   = rd2_data;
  assign VALID2 = rd2_valid;
`endif

endmodule

// File: tb/tb_reg_file_param.sv
// tb/tb_reg_file_param.sv - directed self-checking bench for reg_file_param
module tb_reg_file_param;
  logic       CLK = 1'b0;
  logic       RESET, WRITE, CLEAR;
  logic [7:0] IN;
  logic [2:0] INADDRESS, OUT1ADDRESS, OUT2ADDRESS;
  logic [7:0] OUT1, OUT2, zOUT1, zOUT2;
  logic       VALID1, VALID2, BUSY, zVALID1, zVALID2, zBUSY;
  int         total = 0;
  int         bad   = 0;
  int         cnt;

  always #5 CLK = ~CLK;

  reg_file_param #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .ZERO_REG0(1'b0)) dut (
    .CLK(CLK), .RESET(RESET), .IN(IN), .INADDRESS(INADDRESS), .WRITE(WRITE),
    .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS), .OUT1(OUT1), .OUT2(OUT2),
    .VALID1(VALID1), .VALID2(VALID2), .CLEAR(CLEAR), .BUSY(BUSY)
  );

  reg_file_param #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .ZERO_REG0(1'b1)) dut_z (
    .CLK(CLK), .RESET(RESET), .IN(IN), .INADDRESS(INADDRESS), .WRITE(WRITE),
    .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS), .OUT1(zOUT1), .OUT2(zOUT2),
    .VALID1(zVALID1), .VALID2(zVALID2), .CLEAR(CLEAR), .BUSY(zBUSY)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    WRITE = 1'b1; INADDRESS = a; IN = d;
    tick();
    WRITE = 1'b0;
  endtask

  initial begin
    RESET = 1'b1; WRITE = 1'b0; CLEAR = 1'b0; IN = '0;
    INADDRESS = '0; OUT1ADDRESS = '0; OUT2ADDRESS = '0;
    tick();
    RESET = 1'b0;

    // reset state
    check("reset_busy", BUSY, 0);
    for (int i = 0; i < 8; i++) begin
      OUT1ADDRESS = 3'(i); OUT2ADDRESS = 3'(7 - i); #1;
      check("reset_out1", OUT1, 0);
      check("reset_valid1", VALID1, 0);
      check("reset_out2", OUT2, 0);
      check("reset_valid2", VALID2, 0);
    end
    OUT1ADDRESS = 3'd0; #1;
    check("reset_z_valid0", zVALID1, 1);
    check("reset_z_out0", zOUT1, 0);

    // write/read
    wr(3'd3, 8'hA5);
    wr(3'd7, 8'h5A);
    OUT1ADDRESS = 3'd3; OUT2ADDRESS = 3'd7; #1;
    check("wr_out1", OUT1, 8'hA5);
    check("wr_out2", OUT2, 8'h5A);
    check("wr_valid1", VALID1, 1);
    check("wr_valid2", VALID2, 1);

    // bypass
    wr(3'd2, 8'h11);
    WRITE = 1'b1; INADDRESS = 3'd2; IN = 8'h3C; OUT1ADDRESS = 3'd2; OUT2ADDRESS = 3'd4; #1;
`ifdef REG_FILE_BYPASS_EN
    check("bypass_out1", OUT1, 8'h3C);
`else
    check("bypass_out1", OUT1, 8'h11);
`endif
    check("bypass_valid1", VALID1, 1);
    INADDRESS = 3'd4; IN = 8'h77; #1;
`ifdef REG_FILE_BYPASS_EN
    check("bypass_valid2_new", VALID2, 1);
    check("bypass_out2_new", OUT2, 8'h77);
`else
    check("bypass_valid2_new", VALID2, 0);
    check("bypass_out2_new", OUT2, 8'h00);
`endif
    INADDRESS = 3'd2; IN = 8'h3C;
    tick();
    WRITE = 1'b0; #1;
    check("bypass_after_edge", OUT1, 8'h3C);

    // sweep
    for (int i = 0; i < 8; i++) wr(3'(i), 8'(i + 1));
    OUT1ADDRESS = 3'd5; #1;
    check("fill_r5", OUT1, 8'h06);
    CLEAR = 1'b1; WRITE = 1'b1; INADDRESS = 3'd1; IN = 8'h99;
    tick();
    CLEAR = 1'b0; WRITE = 1'b0;
    check("sweep_busy_start", BUSY, 1);
    OUT1ADDRESS = 3'd1; #1;
    check("clear_write_dropped", OUT1, 8'h02);
    cnt = 0;
    while (BUSY && cnt < 20) begin
      cnt++;
      if (cnt == 3) begin
        OUT1ADDRESS = 3'd1; OUT2ADDRESS = 3'd2; #1;
        check("sweep_cleared_r1", OUT1, 0);
        check("sweep_pending_r2", OUT2, 8'h03);
      end
      if (cnt == 7) begin
        WRITE = 1'b1; INADDRESS = 3'd5; IN = 8'h77; CLEAR = 1'b1;
      end else begin
        WRITE = 1'b0; CLEAR = 1'b0;
      end
      tick();
    end
    WRITE = 1'b0; CLEAR = 1'b0;
    check("sweep_busy_cycles", cnt, 8);
    for (int i = 0; i < 8; i++) begin
      OUT1ADDRESS = 3'(i); #1;
      check("sweep_out", OUT1, 0);
      check("sweep_valid", VALID1, 0);
    end
    tick();
    check("no_queued_clear", BUSY, 0);

    // reset mid-sweep
    wr(3'd4, 8'h44);
    CLEAR = 1'b1;
    tick();
    CLEAR = 1'b0;
    tick();
    tick();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    check("midsweep_busy", BUSY, 0);
    OUT1ADDRESS = 3'd4; OUT2ADDRESS = 3'd7; #1;
    check("midsweep_r4", OUT1, 0);
    check("midsweep_valid4", VALID1, 0);
    CLEAR = 1'b1;
    tick();
    CLEAR = 1'b0;
    cnt = 0;
    while (BUSY && cnt < 20) begin
      cnt++;
      tick();
    end
    check("resweep_cycles", cnt, 8);

    // write with reset
    RESET = 1'b1; WRITE = 1'b1; INADDRESS = 3'd6; IN = 8'h66;
    tick();
    RESET = 1'b0; WRITE = 1'b0;
    OUT1ADDRESS = 3'd6; #1;
    check("reset_beats_write", OUT1, 0);
    check("reset_beats_write_v", VALID1, 0);

    // zero register
    wr(3'd0, 8'hFF);
    OUT1ADDRESS = 3'd0; #1;
    check("zero_reg_out", zOUT1, 0);
    check("zero_reg_valid", zVALID1, 1);
    check("plain_reg0_out", OUT1, 8'hFF);
    check("plain_reg0_valid", VALID1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
